// File: rtl/bist_pattern_gen.sv
// BIST stimulus/check controller for a NOR-MISR compactor: flushes the compactor,
// streams LFSR patterns, then captures and grades the resulting signature.
module bist_pattern_gen #(
   parameter int              WIDTH        = 3,
   parameter logic [WIDTH-1:0] TAPS        = 3'b110,
   parameter logic [WIDTH-1:0] SEED        = 3'b001,
   parameter int              N_PATTERNS   = 7,
   parameter int              FLUSH_CYCLES = 1,
   parameter logic [WIDTH-1:0] GOLDEN      = 3'b000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] SIG,
   output logic [WIDTH-1:0] PAT,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [WIDTH-1:0] SIG_CAP
);

   localparam int CNT_W  = $clog2(N_PATTERNS + 1);
   localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [WIDTH-1:0]  ONES   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]  ZEROS  = {WIDTH{1'b0}};
   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   localparam logic [WIDTH-1:0]  SEED_L = (SEED == ZEROS) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_PATTERNS - 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   state_t             state_r, state_s;
   logic [WIDTH-1:0]   pat_r, pat_s;
   logic               busy_r, busy_s;
   logic               done_r, done_s;
   logic               pass_r, pass_s;
   logic [WIDTH-1:0]   sig_cap_r, sig_cap_s;
   logic [WIDTH-1:0]   lfsr_r, lfsr_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [FCNT_W-1:0]  fcnt_r, fcnt_s;

   // Next-state and next-register values; outputs are all registered below.
   always_comb begin
      state_s   = state_r;
      pat_s     = ONES;
      done_s    = 1'b0;
      pass_s    = pass_r;
      sig_cap_s = sig_cap_r;
      lfsr_s    = lfsr_r;
      cnt_s     = cnt_r;
      fcnt_s    = fcnt_r;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_s = ST_FLUSH;
               pass_s  = 1'b0;
               lfsr_s  = SEED_L;
               cnt_s   = {CNT_W{1'b0}};
               fcnt_s  = {FCNT_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (fcnt_r == FCNT_LAST) begin
               state_s = ST_RUN;
               pat_s   = lfsr_r;
            end else begin
               fcnt_s  = fcnt_r + FCNT_W'(1'b1);
            end
         end
         ST_RUN: begin
            lfsr_s = lfsr_step(lfsr_r);
            cnt_s  = cnt_r + CNT_W'(1'b1);
            if (cnt_r == CNT_LAST) begin
               state_s = ST_CHECK;
            end else begin
               pat_s   = lfsr_step(lfsr_r);
            end
         end
         ST_CHECK: begin
            // SIG now reflects every pattern of the run.
            sig_cap_s = SIG;
            pass_s    = (SIG == GOLDEN);
            done_s    = 1'b1;
            state_s   = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pat_r     <= ONES;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
         sig_cap_r <= ZEROS;
         lfsr_r    <= SEED_L;
         cnt_r     <= {CNT_W{1'b0}};
         fcnt_r    <= {FCNT_W{1'b0}};
      end else begin
         pat_r     <= pat_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         pass_r    <= pass_s;
         sig_cap_r <= sig_cap_s;
         lfsr_r    <= lfsr_s;
         cnt_r     <= cnt_s;
         fcnt_r    <= fcnt_s;
      end
   end

   assign PAT     = pat_r;
   assign BUSY    = busy_r;
   assign DONE    = done_r;
   assign PASS    = pass_r;
   assign SIG_CAP = sig_cap_r;

endmodule
